pixel_scale_addr_gen: RTL and testbench
=======================================

# pixel_scale_addr_gen

Parametrised successor of the single-axis line-period counter in the VGA display path. It generates the vertical sub-line index, the vertical sub-pixel index and the horizontal sub-pixel index from the VGA timing counters. From those it produces the logical (row, column) address of an upscaled framebuffer pixel, plus row/frame strobes for the memory-read logic. It sits between the VGA sync generator (H_counter, H_pixel_disp, V_pixel_disp) and the framebuffer address/read stage.

## Interface
Parameters:
- HC_W, 12, width of H_counter
- H_LAST, 3199, H_counter value on the last clock of a line
- CLK_PER_PIX, 4, clocks per VGA pixel
- H_SCALE, 5, VGA pixels per logical pixel horizontally
- V_SCALE, 5, VGA lines per logical pixel vertically
- COLS, 128, logical columns per row
- ROWS, 96, logical rows per frame

Ports (widths: LW=clog2(V_SCALE), PW=clog2(H_SCALE), DW=clog2(CLK_PER_PIX), CW=clog2(COLS), RW=clog2(ROWS), each minimum 1):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- H_counter  in  HC_W  horizontal clock counter from the sync generator
- H_pixel_disp  in  1  high during the horizontal visible region
- V_pixel_disp  in  1  high during the vertical visible region
- line_count  out  LW  VGA line index within the current logical row, 0..V_SCALE-1
- row_addr  out  RW  logical row, 0..ROWS-1
- clk_div  out  DW  clock index within the current VGA pixel
- pix_count  out  PW  VGA pixel index within the current logical pixel
- col_addr  out  CW  logical column, 0..COLS-1
- addr_valid  out  1  registered (H_pixel_disp & V_pixel_disp)
- row_done  out  1  one-clock pulse when line_count wraps
- frame_done  out  1  one-clock pulse when row_addr wraps from ROWS-1 to 0

## Operation
- Reset (reset=0, asynchronous): every output is 0.
- Vertical chain, evaluated each clk. Priority order:
  1. V_pixel_disp=0: line_count, row_addr and row_done are cleared.
  2. H_counter==H_LAST with line_count==V_SCALE-1: line_count becomes 0, row_done pulses and row_addr advances.
  3. H_counter==H_LAST otherwise: line_count increments.
  4. Otherwise: all hold.
- row_addr advance: row_addr==ROWS-1 wraps to 0 and pulses frame_done; otherwise +1.
- Horizontal chain, evaluated each clk:
  - H_pixel_disp=0: clk_div, pix_count and col_addr are cleared.
  - Otherwise clk_div counts modulo CLK_PER_PIX.
  - When clk_div==CLK_PER_PIX-1, pix_count counts modulo H_SCALE.
  - When pix_count also wraps, col_addr increments and saturates at COLS-1. It never wraps inside a line.
- Horizontal and vertical chains are independent. A clear on one axis never affects the other.
- row_done and frame_done are 0 whenever the condition is not met in that cycle.

## Timing
- All outputs are registered. Each responds one clk after the sampled input condition. There is no combinational input-to-output path.
- V_pixel_disp falling in the same cycle as H_counter==H_LAST: the clear wins. line_count=0 and row_done=0 next cycle.
- Deassertion of reset mid-frame: counters start from 0. Alignment is regained at the next V_pixel_disp low period.
- With CLK_PER_PIX=1 or H_SCALE=1, the corresponding counter is constant 0 and every enable passes straight through.
- With defaults, row_addr reaches 95 on line 475. The frame_done pulse occurs only if V_pixel_disp remains high past line 479.

## Structure
- Shared package pixel_scale_pkg holds:
  - the default parameter constants (H_LAST_DEF, V_SCALE_DEF, etc.);
  - a clog2-with-minimum-1 width function.
- One sub-module: mod_counter.
  - Parameters: MOD, W, SATURATE.
  - Ports: clk, reset, clr, en, count, wrap.
  - The wrap output is a combinational "at terminal and enabled" signal.
- Instances: five mod_counter, chained through wrap→en:
  - line_count → row_addr
  - clk_div → pix_count → col_addr
- The top level registers row_done, frame_done and addr_valid.

## Test plan
- Reset: drive reset=0 mid-line with counters non-zero → all outputs 0 in the same cycle, held until reset=1.
- Vertical wrap with defaults: hold V_pixel_disp=1 and sweep H_counter 0..3199 over five lines → line_count steps 1,2,3,4,0; row_done pulses exactly once, with row_addr 0→1 in the same cycle.
- Horizontal scaling with defaults: H_pixel_disp=1 for 640×4 clocks → col_addr changes every 20 clocks and ends at 127; clk_div and pix_count cycle 0..3 and 0..4.
- Priority: V_pixel_disp=0 in the same cycle as H_counter=3199 with line_count=4 → next cycle line_count=0, row_addr=0, row_done=0.
- Frame wrap: set ROWS=4 and V_SCALE=2, keep V_pixel_disp high for 8 lines → frame_done pulses once at the end of line 8 and row_addr returns to 0.
- Degenerate parameters: CLK_PER_PIX=1, H_SCALE=1, COLS=640 → col_addr increments every clock of H_pixel_disp and saturates at 639.

Source files
------------

// File: rtl/pixel_scale_pkg.sv
// Shared defaults and width helper for the pixel scale address generator.
package pixel_scale_pkg;

  localparam int HC_W_DEF        = 12;
  localparam int H_LAST_DEF      = 3199;
  localparam int CLK_PER_PIX_DEF = 4;
  localparam int H_SCALE_DEF     = 5;
  localparam int V_SCALE_DEF     = 5;
  localparam int COLS_DEF        = 128;
  localparam int ROWS_DEF        = 96;

  // Bits needed to hold 0..value-1, never less than one bit so a
  // modulus of 1 still yields a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pixel_scale_addr_gen_mod_counter.sv
// Modulo (or saturating) counter with synchronous clear and chainable wrap.
module mod_counter #(
  parameter int MOD      = 4,
  parameter int W        = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic at_last;

  // Terminal-count detect; with MOD=1 this is always true so wrap == en.
  always_comb begin
    at_last = (count == LAST);
    wrap    = en & at_last;
  end

  // Count state: clear beats enable; terminal either wraps or holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (en) begin
      if (at_last) begin
        count <= SATURATE ? LAST : {W{1'b0}};
      end else begin
        count <= count + W'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pixel_scale_addr_gen.sv
// Converts VGA timing counters into upscaled framebuffer (row, column)
// addresses plus row/frame strobes for the read stage.
module pixel_scale_addr_gen
  import pixel_scale_pkg::*;
#(
  parameter int HC_W        = HC_W_DEF,
  parameter int H_LAST      = H_LAST_DEF,
  parameter int CLK_PER_PIX = CLK_PER_PIX_DEF,
  parameter int H_SCALE     = H_SCALE_DEF,
  parameter int V_SCALE     = V_SCALE_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int ROWS        = ROWS_DEF
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [HC_W-1:0]                    H_counter,
  input  logic                               H_pixel_disp,
  input  logic                               V_pixel_disp,
  output logic [clog2_min1(V_SCALE)-1:0]     line_count,
  output logic [clog2_min1(ROWS)-1:0]        row_addr,
  output logic [clog2_min1(CLK_PER_PIX)-1:0] clk_div,
  output logic [clog2_min1(H_SCALE)-1:0]     pix_count,
  output logic [clog2_min1(COLS)-1:0]        col_addr,
  output logic                               addr_valid,
  output logic                               row_done,
  output logic                               frame_done
);

  localparam int LW = clog2_min1(V_SCALE);
  localparam int RW = clog2_min1(ROWS);
  localparam int DW = clog2_min1(CLK_PER_PIX);
  localparam int PW = clog2_min1(H_SCALE);
  localparam int CW = clog2_min1(COLS);

  logic line_en;
  logic line_wrap;
  logic row_wrap;
  logic div_wrap;
  logic pix_wrap;
  logic col_wrap_unused;

  // Line step fires only inside the vertical visible region, so a clear
  // in the same cycle as the last H clock can never produce a strobe.
  always_comb begin
    line_en = V_pixel_disp & (H_counter == HC_W'(H_LAST));
  end

  // Vertical chain: line within logical row, then logical row.
  mod_counter #(.MOD(V_SCALE), .W(LW), .SATURATE(1'b0)) u_line (
    .clk(clk), .reset(reset), .clr(~V_pixel_disp), .en(line_en),
    .count(line_count), .wrap(line_wrap)
  );

  mod_counter #(.MOD(ROWS), .W(RW), .SATURATE(1'b0)) u_row (
    .clk(clk), .reset(reset), .clr(~V_pixel_disp), .en(line_wrap),
    .count(row_addr), .wrap(row_wrap)
  );

  // Horizontal chain: clock within pixel, pixel within logical pixel,
  // then logical column (saturating so it never wraps inside a line).
  mod_counter #(.MOD(CLK_PER_PIX), .W(DW), .SATURATE(1'b0)) u_div (
    .clk(clk), .reset(reset), .clr(~H_pixel_disp), .en(H_pixel_disp),
    .count(clk_div), .wrap(div_wrap)
  );

  mod_counter #(.MOD(H_SCALE), .W(PW), .SATURATE(1'b0)) u_pix (
    .clk(clk), .reset(reset), .clr(~H_pixel_disp), .en(div_wrap),
    .count(pix_count), .wrap(pix_wrap)
  );

  mod_counter #(.MOD(COLS), .W(CW), .SATURATE(1'b1)) u_col (
    .clk(clk), .reset(reset), .clr(~H_pixel_disp), .en(pix_wrap),
    .count(col_addr), .wrap(col_wrap_unused)
  );

  // Registered strobes and visible-region flag, aligned with the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      addr_valid <= 1'b0;
    end else begin
      row_done   <= line_wrap;
      frame_done <= row_wrap;
      addr_valid <= H_pixel_disp & V_pixel_disp;
    end
  end

endmodule

// File: tb/tb_pixel_scale_addr_gen.sv
// Directed bench: three parameterisations share one stimulus stream.
module tb_pixel_scale_addr_gen;

  logic        clk;
  logic        reset;
  logic [11:0] H_counter;
  logic        H_pixel_disp;
  logic        V_pixel_disp;

  int n_checks;
  int n_fail;
  int pulses;

  // dut_a: defaults
  logic [2:0] a_line; logic [6:0] a_row; logic [1:0] a_div; logic [2:0] a_pix;
  logic [6:0] a_col;  logic a_valid, a_rdone, a_fdone;
  // dut_b: ROWS=4, V_SCALE=2
  logic [0:0] b_line; logic [1:0] b_row; logic [1:0] b_div; logic [2:0] b_pix;
  logic [6:0] b_col;  logic b_valid, b_rdone, b_fdone;
  // dut_c: CLK_PER_PIX=1, H_SCALE=1, COLS=640
  logic [2:0] c_line; logic [6:0] c_row; logic [0:0] c_div; logic [0:0] c_pix;
  logic [9:0] c_col;  logic c_valid, c_rdone, c_fdone;

  pixel_scale_addr_gen dut_a (
    .clk(clk), .reset(reset), .H_counter(H_counter),
    .H_pixel_disp(H_pixel_disp), .V_pixel_disp(V_pixel_disp),
    .line_count(a_line), .row_addr(a_row), .clk_div(a_div), .pix_count(a_pix),
    .col_addr(a_col), .addr_valid(a_valid), .row_done(a_rdone), .frame_done(a_fdone)
  );

  pixel_scale_addr_gen #(.ROWS(4), .V_SCALE(2)) dut_b (
    .clk(clk), .reset(reset), .H_counter(H_counter),
    .H_pixel_disp(H_pixel_disp), .V_pixel_disp(V_pixel_disp),
    .line_count(b_line), .row_addr(b_row), .clk_div(b_div), .pix_count(b_pix),
    .col_addr(b_col), .addr_valid(b_valid), .row_done(b_rdone), .frame_done(b_fdone)
  );

  pixel_scale_addr_gen #(.CLK_PER_PIX(1), .H_SCALE(1), .COLS(640)) dut_c (
    .clk(clk), .reset(reset), .H_counter(H_counter),
    .H_pixel_disp(H_pixel_disp), .V_pixel_disp(V_pixel_disp),
    .line_count(c_line), .row_addr(c_row), .clk_div(c_div), .pix_count(c_pix),
    .col_addr(c_col), .addr_valid(c_valid), .row_done(c_rdone), .frame_done(c_fdone)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {a_line, a_row, a_div, a_pix, a_col, a_valid, a_rdone, a_fdone}, 32'd0);
    chk({tag, "_b"}, {b_line, b_row, b_div, b_pix, b_col, b_valid, b_rdone, b_fdone}, 32'd0);
    chk({tag, "_c"}, {c_line, c_row, c_div, c_pix, c_col, c_valid, c_rdone, c_fdone}, 32'd0);
  endtask

  task automatic line_end();
    H_counter = 12'd3199;
    tick();
    H_counter = 12'd0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pulses = 0;
    reset = 1'b1; H_counter = 12'd0; H_pixel_disp = 1'b0; V_pixel_disp = 1'b0;
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_initial");
    tick(); tick();
    chk_all_zero("reset_held");
    reset = 1'b1;

    // Horizontal scaling, V low so vertical stays idle.
    H_pixel_disp = 1'b1;
    for (int k = 1; k <= 2565; k++) begin
      tick();
      chk("a_clk_div", a_div, k % 4);
      chk("a_pix_count", a_pix, (k / 4) % 5);
      chk("a_col_addr", a_col, ((k / 20) > 127) ? 127 : (k / 20));
      chk("c_col_addr", c_col, (k > 639) ? 639 : k);
      chk("c_div_pix", {c_div, c_pix}, 32'd0);
      chk("a_valid_vlow", a_valid, 32'd0);
      chk("a_line_idle", a_line, 32'd0);
    end

    // Asynchronous reset mid-line, between clock edges.
    #3 reset = 1'b0;
    #1 chk_all_zero("reset_midline");
    tick(); tick();
    chk_all_zero("reset_midline_held");
    reset = 1'b1;
    H_pixel_disp = 1'b0;

    // Vertical wrap with defaults: five full H sweeps.
    V_pixel_disp = 1'b1;
    for (int l = 1; l <= 5; l++) begin
      for (int h = 0; h <= 3199; h++) begin
        H_counter = 12'(h);
        tick();
        if (a_rdone) pulses++;
      end
      chk("v_line_count", a_line, l % 5);
      chk("v_row_addr", a_row, (l == 5) ? 1 : 0);
      chk("v_row_done", a_rdone, (l == 5) ? 1 : 0);
      chk("b_line_count", b_line, l % 2);
    end
    H_counter = 12'd0;
    tick();
    if (a_rdone) pulses++;
    chk("v_row_done_pulses", pulses, 32'd1);
    chk("v_col_idle", a_col, 32'd0);

    // Priority: bring line_count to 4 then drop V on the last H clock.
    for (int l = 0; l < 4; l++) line_end();
    tick();
    chk("p_line_pre", a_line, 32'd4);
    chk("p_row_pre", a_row, 32'd1);
    V_pixel_disp = 1'b0;
    H_counter = 12'd3199;
    tick();
    chk("p_line", a_line, 32'd0);
    chk("p_row", a_row, 32'd0);
    chk("p_row_done", a_rdone, 32'd0);
    chk("p_frame_done", a_fdone, 32'd0);
    H_counter = 12'd0;

    // Frame wrap on dut_b over eight lines.
    V_pixel_disp = 1'b1;
    tick();
    pulses = 0;
    for (int l = 1; l <= 8; l++) begin
      line_end();
      if (b_fdone) pulses++;
      chk("f_line", b_line, l % 2);
      chk("f_row", b_row, (l / 2) % 4);
      chk("f_row_done", b_rdone, (l % 2 == 0) ? 1 : 0);
      chk("f_frame_done", b_fdone, (l == 8) ? 1 : 0);
      tick();
      if (b_fdone) pulses++;
      chk("f_strobes_low", {b_rdone, b_fdone}, 32'd0);
    end
    chk("f_frame_pulses", pulses, 32'd1);
    chk("f_a_line", a_line, 32'd3);
    chk("f_a_row", a_row, 32'd1);

    // Axis independence and addr_valid.
    H_pixel_disp = 1'b1;
    tick(); tick(); tick();
    chk("i_clk_div", a_div, 32'd3);
    chk("i_valid", a_valid, 32'd1);
    chk("i_line_kept", a_line, 32'd3);
    H_pixel_disp = 1'b0;
    tick();
    chk("i_h_clear", {a_div, a_pix, a_col}, 32'd0);
    chk("i_valid_low", a_valid, 32'd0);
    chk("i_line_kept2", a_line, 32'd3);
    chk("i_row_kept", a_row, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
